// File: rtl/t_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : t_count_ctrl
// Description : Start/stop sequencer that drives a WIDTH-bit toggle-flop bank
//               as an up/down counter with a programmable limit and reload.
// Revision    : 1.0 - initial release
// ============================================================================
module t_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] t_en,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             r_dir;
    logic             r_auto;
    logic [WIDTH-1:0] r_limit;
    logic             r_done;
    logic             r_wrap;
    logic             w_done_nxt;
    logic             w_wrap_nxt;
    logic             w_latch;

    logic [WIDTH-1:0] w_start_val;
    logic [WIDTH-1:0] w_term_val;
    logic             w_at_term;
    logic [WIDTH-1:0] w_up;
    logic [WIDTH-1:0] w_dn;
    logic [WIDTH-1:0] w_toggle;

    assign w_start_val = r_dir ? '0 : r_limit;
    assign w_term_val  = r_dir ? r_limit : '0;
    assign w_at_term   = (r_q == w_term_val);

    // Carry/borrow chains: bit i toggles when all lower bits are 1 (up) or 0 (down)
    assign w_up[0] = 1'b1;
    assign w_dn[0] = 1'b1;
    generate
        for (genvar i = 1; i < WIDTH; i++) begin : g_chain
            assign w_up[i] = w_up[i-1] &  r_q[i-1];
            assign w_dn[i] = w_dn[i-1] & ~r_q[i-1];
        end
    endgenerate

    assign w_toggle = ((r_state == ST_COUNT) && !stop && !w_at_term)
                      ? (r_dir ? w_up : w_dn) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_done_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_latch     = 1'b1;
                    w_q_nxt     = dir ? '0 : limit;
                    w_state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (stop) begin
                    w_state_nxt = ST_PAUSE;
                end else if (w_at_term) begin
                    w_done_nxt = 1'b1;
                    if (r_auto) begin
                        w_q_nxt    = w_start_val;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_q_nxt = r_q ^ w_toggle;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (start) begin
                    w_state_nxt = ST_COUNT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_dir   <= 1'b1;
            r_auto  <= 1'b0;
            r_limit <= '0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_done  <= w_done_nxt;
            r_wrap  <= w_wrap_nxt;
            if (w_latch) begin
                r_dir   <= dir;
                r_auto  <= auto_reload;
                r_limit <= limit;
            end
        end
    end

    assign t_en = w_toggle;
    assign q    = r_q;
    assign busy = (r_state == ST_COUNT) || (r_state == ST_PAUSE);
    assign done = r_done;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_t_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_t_count_ctrl
// Description : Directed self-checking bench for t_count_ctrl (WIDTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t_count_ctrl;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             dir;
    logic             auto_reload;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] t_en;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             wrap;

    int checks = 0;
    int errors = 0;

    t_count_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .dir         (dir),
        .auto_reload (auto_reload),
        .limit       (limit),
        .t_en        (t_en),
        .q           (q),
        .busy        (busy),
        .done        (done),
        .wrap        (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0;
        auto_reload = 1'b0; limit = '0;
        tick(); tick();
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_ten", t_en, 0);
        rst = 1'b0;

        // Up count to 5, one-shot
        dir = 1'b1; limit = 4'd5; auto_reload = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        chk("up_q0", q, 0);
        chk("up_busy", busy, 1);
        chk("up_ten0", t_en, 4'b0001);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("up_q", q, k);
            chk("up_done_low", done, 0);
            if (k == 3) chk("up_ten3", t_en, 4'b0111);
        end
        chk("up_ten_term", t_en, 0);
        tick();
        chk("up_done", done, 1);
        chk("up_busy_fall", busy, 0);
        chk("up_hold", q, 5);
        tick();
        chk("up_done_pulse", done, 0);
        chk("up_hold2", q, 5);

        // Down count from 9; inputs changed while busy must be ignored
        dir = 1'b0; limit = 4'd9; start = 1'b1;
        tick(); start = 1'b0; dir = 1'b1; limit = 4'd2;
        chk("dn_q9", q, 9);
        chk("dn_ten9", t_en, 4'b0001);
        tick();
        chk("dn_q8", q, 8);
        chk("dn_ten8", t_en, 4'b1111);
        for (int k = 7; k >= 0; k--) begin
            tick();
            chk("dn_q", q, k);
            chk("dn_done_low", done, 0);
        end
        tick();
        chk("dn_done", done, 1);
        chk("dn_busy", busy, 0);
        chk("dn_hold", q, 0);

        // Auto-reload up to 3
        dir = 1'b1; limit = 4'd3; auto_reload = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        chk("ar_q0", q, 0);
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 3; k++) begin
                tick();
                chk("ar_q", q, k);
                chk("ar_wrap_low", wrap, 0);
            end
            tick();
            chk("ar_reload_q", q, 0);
            chk("ar_done", done, 1);
            chk("ar_wrap", wrap, 1);
            chk("ar_busy", busy, 1);
        end
        tick();
        chk("ar_q1", q, 1);
        chk("ar_done_pulse", done, 0);
        chk("ar_wrap_pulse", wrap, 0);
        stop = 1'b1;
        tick();
        chk("ar_pause_q", q, 1);
        chk("ar_pause_busy", busy, 1);
        tick();
        chk("ar_abort_busy", busy, 0);
        stop = 1'b0;

        // Pause/resume/abort
        auto_reload = 1'b0; dir = 1'b1; limit = 4'd7; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        chk("pr_q2", q, 2);
        stop = 1'b1; #1;
        chk("pr_ten_stop", t_en, 0);
        tick(); stop = 1'b0; #1;
        chk("pr_pause_q", q, 2);
        chk("pr_pause_ten", t_en, 0);
        chk("pr_pause_busy", busy, 1);
        tick();
        chk("pr_pause_hold", q, 2);
        start = 1'b1;
        tick(); start = 1'b0;
        chk("pr_resume_q", q, 2);
        tick();
        chk("pr_q3", q, 3);
        stop = 1'b1;
        tick();
        chk("pr_pause2_q", q, 3);
        tick();
        chk("pr_abort_busy", busy, 0);
        chk("pr_abort_done", done, 0);
        chk("pr_abort_q", q, 3);
        stop = 1'b0;

        // start and stop together in IDLE: nothing happens
        start = 1'b1; stop = 1'b1;
        tick();
        chk("ss_busy", busy, 0);
        chk("ss_q", q, 3);
        start = 1'b0; stop = 1'b0;

        // stop on the terminal cycle suppresses done until resume
        dir = 1'b1; limit = 4'd2; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        chk("st_q2", q, 2);
        stop = 1'b1;
        tick(); stop = 1'b0;
        chk("st_no_done", done, 0);
        chk("st_paused", busy, 1);
        start = 1'b1;
        tick(); start = 1'b0;
        chk("st_resume_done_low", done, 0);
        tick();
        chk("st_done", done, 1);
        chk("st_idle", busy, 0);

        // limit = 0 finishes after one edge
        dir = 1'b1; limit = 4'd0; start = 1'b1;
        tick(); start = 1'b0;
        chk("lz_q", q, 0);
        chk("lz_ten", t_en, 0);
        tick();
        chk("lz_done", done, 1);
        chk("lz_busy", busy, 0);

        // Reset mid-count, then new config takes effect
        dir = 1'b1; limit = 4'd12; start = 1'b1;
        tick(); start = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        chk("rm_q6", q, 6);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("rm_q", q, 0);
        chk("rm_busy", busy, 0);
        chk("rm_done", done, 0);
        chk("rm_ten", t_en, 0);
        dir = 1'b0; limit = 4'd3; start = 1'b1;
        tick(); start = 1'b0;
        chk("rm_new_q", q, 3);
        chk("rm_new_busy", busy, 1);
        for (int k = 2; k >= 0; k--) begin
            tick();
            chk("rm_dn_q", q, k);
        end
        tick();
        chk("rm_done_new", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/t_count_ctrl.md
Name: t_count_ctrl

Overview:
- Sequencing controller for a bank of WIDTH toggle (T) flip-flops. Turns the bank into a start/stop-controlled up/down counter with a programmable limit and optional auto-reload.
- Generates the per-bit toggle-enable vector and holds the T-bank internally (q <= q ^ t_en). t_en is also exported so a matching external T-flop bank can be driven in lockstep.
- Sits between a host control interface and toggle-cell datapaths.

Parameters:
- WIDTH, 4, number of T-cells / counter bits (>=2)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  level-sampled command: begin (IDLE) or resume (PAUSE)
- stop  input  1  level-sampled command: pause (COUNT) or abort (PAUSE)
- dir  input  1  1 = count up, 0 = count down; sampled only on start from IDLE
- auto_reload  input  1  1 = restart at terminal, 0 = one-shot; sampled on start from IDLE
- limit  input  WIDTH  count limit; sampled on start from IDLE
- t_en  output  WIDTH  toggle-enable vector applied this cycle
- q  output  WIDTH  current T-bank value
- busy  output  1  high in COUNT or PAUSE
- done  output  1  one-cycle pulse at terminal count
- wrap  output  1  one-cycle pulse when auto-reload restarts the count

Behaviour:
- Reset is synchronous and active-high (rst sampled on clk rising edge). It overrides all other inputs.
  - Values after reset: state IDLE, q=0, dir_r=1, auto_r=0, limit_r=0, done=0, wrap=0, busy=0, t_en=0.
- States: IDLE, COUNT, PAUSE. busy is decoded from state (COUNT|PAUSE).
- Latched config: dir_r, auto_r, limit_r are captured only on the IDLE->COUNT edge. Input changes while busy are ignored.
- Start value: S = 0 if dir_r=1, else limit_r.
- Terminal value: T = limit_r if dir_r=1, else 0.
- IDLE:
  - start=1 and stop=0 -> latch config, q <= S (from the sampled inputs), go to COUNT.
  - Otherwise hold q.
- COUNT, q != T:
  - t_en is a combinational function of q, dir_r and state.
  - Up: t_en[0]=1, t_en[i] = &q[i-1:0].
  - Down: t_en[0]=1, t_en[i] = &(~q[i-1:0]).
  - q <= q ^ t_en, i.e. +1 / -1 modulo 2^WIDTH.
- COUNT, q == T:
  - t_en=0 and done <= 1.
  - If auto_r=1: q <= S, wrap <= 1, stay in COUNT.
  - Else: hold q, go to IDLE.
- COUNT with stop=1: go to PAUSE and hold q, t_en=0.
  - Stop wins over terminal detection in the same cycle: no done pulse, and the terminal is re-evaluated on resume.
- PAUSE:
  - stop=1 -> IDLE (abort), q held, no done.
  - Else start=1 -> COUNT.
  - Else hold.
- Simultaneous start and stop: stop has priority in every state. In IDLE, that combination does nothing.
- done and wrap are registered and high for exactly one cycle per terminal event.
- t_en is 0 in every state other than COUNT, and at q==T.
- Latency: start sampled at edge n gives q=S after edge n. The first toggle happens at edge n+1. done is visible after edge n+|T-S|+1.
- limit=0: up-mode start loads 0 = T, so done arrives after the next edge (counted zero steps). The same holds in down mode.
- Counting never passes T, so no overflow is possible inside a run.
- rst asserted in any state, including mid-count or PAUSE, returns to reset values on that edge. No done pulse is produced.

Test Plan:
- Reset, then start=1 for 1 cycle with dir=1, limit=5, auto_reload=0 -> q reads 0,1,2,3,4,5 on successive cycles; done=1 for one cycle on the 7th cycle after the start edge; busy falls with done; q holds 5.
- Down mode, dir=0, limit=9, WIDTH=4 -> q reads 9,8,...,0, then one done pulse; t_en=4'b1111 on the 8->7 step and 4'b0001 on the 9->8 step.
- auto_reload=1, dir=1, limit=3 -> q cycles 0,1,2,3,0,1,...; done and wrap pulse together each time q leaves 3; busy stays 1.
- Start, then stop=1 at q=2 for one cycle -> q holds 2 with t_en=0 while paused; start=1 resumes at 3; a second stop in PAUSE returns to IDLE with no done pulse.
- start and stop both high in IDLE -> state stays IDLE and q unchanged; stop at the same edge as q==T -> PAUSE with no done; done follows resume.
- Assert rst mid-count at q=6 (limit=12) -> after that edge q=0, busy=0, done=0, t_en=0; a later start with changed limit/dir takes effect.
